// File: rtl/perf_monitor_pkg.sv
// Shared types and constants for the performance-monitor peripheral:
// FSM states, CTRL command codes and register-window offsets.
package perf_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FINI = 2'd2
  } state_e;

  localparam logic [1:0] CMD_NOP    = 2'b00;
  localparam logic [1:0] CMD_START  = 2'b01;
  localparam logic [1:0] CMD_FINISH = 2'b10;
  localparam logic [1:0] CMD_CLEAR  = 2'b11;

  localparam logic [4:0] OFS_CTRL = 5'h00;
  localparam logic [4:0] OFS_CYC  = 5'h04;
  localparam logic [4:0] OFS_RET  = 5'h08;
  localparam logic [4:0] OFS_BP   = 5'h0C;
  localparam logic [4:0] OFS_BM   = 5'h10;

endpackage

// File: rtl/perf_monitor_counter.sv
// One wrapping event counter with a sticky overflow flag set on the
// all-ones to zero transition.
module perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             ovf_o
);

  always_ff @(posedge clk_i) begin
    if (!rst_n || clr_i) begin
      cnt_o <= '0;
      ovf_o <= 1'b0;
    end else if (en_i && inc_i) begin
      cnt_o <= cnt_o + CNT_W'(1);
      if (&cnt_o) ovf_o <= 1'b1;
    end
  end

endmodule

// File: rtl/perf_monitor.sv
// Memory-mapped performance monitor: counts cycles, retires, branches and
// mispredicts while in RUN; CTRL writes drive the IDLE/RUN/FINI state machine.
module perf_monitor
  import perf_monitor_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h40008000,
  parameter int          CNT_W      = 32,
  parameter bit          AUTO_START = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        retire_i,
  input  logic        br_i,
  input  logic        br_misp_i,
  input  logic [31:0] dbus_addr_i,
  input  logic        dbus_we_i,
  input  logic        dbus_re_i,
  input  logic [31:0] dbus_wdata_i,
  output logic [31:0] dbus_rdata_o,
  output logic        dbus_rvalid_o,
  output logic        running_o,
  output logic        fini_o
);

  state_e           state, state_nx;
  logic             hit, ctrl_wr, clr, en;
  logic [1:0]       cmd;
  logic [4:0]       ofs;
  logic [3:0]       inc, ovf;
  logic [CNT_W-1:0] cnt [4];
  logic [31:0]      rd_val, rd_data_p1;
  logic             vld_p1;
  logic             unused_bits;

  assign hit     = (dbus_addr_i[31:5] == BASE_ADDR[31:5]);
  assign ofs     = {dbus_addr_i[4:2], 2'b00};
  assign cmd     = dbus_wdata_i[17:16];
  assign ctrl_wr = dbus_we_i && hit && (ofs == OFS_CTRL);
  // START/CLEAR are ignored once finished so the frozen counts survive readout.
  assign clr     = ctrl_wr && (state != FINI) && ((cmd == CMD_START) || (cmd == CMD_CLEAR));
  assign en      = (state == RUN) && !clr;
  assign inc     = {br_i & br_misp_i, br_i, retire_i, 1'b1};

  assign unused_bits = ^{dbus_wdata_i[31:18], dbus_wdata_i[15:0], dbus_addr_i[1:0]};

  always_ff @(posedge clk_i) begin
    if (!rst_n) state <= AUTO_START ? RUN : IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (ctrl_wr) begin
      case (state)
        IDLE: begin
          if (cmd == CMD_START)       state_nx = RUN;
          else if (cmd == CMD_FINISH) state_nx = FINI;
        end
        RUN: begin
          if (cmd == CMD_FINISH) state_nx = FINI;
        end
        default: state_nx = state;
      endcase
    end
  end

  always_comb begin
    running_o = (state == RUN);
    fini_o    = (state == FINI);
  end

  for (genvar i = 0; i < 4; i++) begin : g_cnt
    perf_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk_i (clk_i),
      .rst_n (rst_n),
      .clr_i (clr),
      .inc_i (inc[i]),
      .en_i  (en),
      .cnt_o (cnt[i]),
      .ovf_o (ovf[i])
    );
  end

  always_comb begin
    rd_val = '0;
    case (ofs)
      OFS_CTRL: begin
        rd_val[1:0] = state;
        rd_val[7:4] = ovf;
      end
      OFS_CYC: rd_val[CNT_W-1:0] = cnt[0];
      OFS_RET: rd_val[CNT_W-1:0] = cnt[1];
      OFS_BP:  rd_val[CNT_W-1:0] = cnt[2];
      OFS_BM:  rd_val[CNT_W-1:0] = cnt[3];
      default: rd_val = '0;
    endcase
  end

  // Read stage: capture the pre-edge register value one cycle after the request.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      vld_p1     <= 1'b0;
      rd_data_p1 <= '0;
    end else begin
      vld_p1 <= dbus_re_i && hit;
      if (dbus_re_i && hit) rd_data_p1 <= rd_val;
    end
  end

  assign dbus_rdata_o  = rd_data_p1;
  assign dbus_rvalid_o = vld_p1;

endmodule

// File: doc/perf_monitor.md
Name: perf_monitor

Overview:
- Memory-mapped performance-monitor peripheral on the data bus, directly downstream of the CPU pipeline's retire/branch-resolve event signals.
- Counts cycles, retired instructions, branch predictions and branch mispredictions.
- Exposes the counts as read-only registers.
- Decodes the simulation-control word at 0x40008000: wdata[17:16]==2'b10 freezes the counters and raises fini_o, which the bench uses to end the run.

Parameters:
- BASE_ADDR, 32'h40008000, base of the 32-byte register window; the CTRL register is at offset 0x0.
- CNT_W, 32, counter width, 1..32; counters wrap modulo 2^CNT_W.
- AUTO_START, 1, 1: leave reset in RUN; 0: leave reset in IDLE.

Ports:
- clk_i  in  1  system clock.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk_i.
- retire_i  in  1  one instruction retires this cycle (ExMa valid and not stalled).
- br_i  in  1  a control-transfer instruction resolves this cycle.
- br_misp_i  in  1  the resolving control transfer was mispredicted; ignored unless br_i=1.
- dbus_addr_i  in  32  data-bus byte address.
- dbus_we_i  in  1  write strobe; full-word writes only.
- dbus_re_i  in  1  read strobe.
- dbus_wdata_i  in  32  write data.
- dbus_rdata_o  out  32  read data; valid one cycle after dbus_re_i.
- dbus_rvalid_o  out  1  read-data-valid pulse.
- running_o  out  1  high in state RUN.
- fini_o  out  1  sticky finish flag.

Behaviour:
- Reset: all counters 0, overflow bits 0, fini_o=0, dbus_rdata_o=0, dbus_rvalid_o=0. State is RUN if AUTO_START=1, else IDLE. running_o follows the state.
- Register map (offsets from BASE_ADDR):
  - 0x00 CTRL/STATUS. Write: bits[17:16] = cmd. Read: [1:0]=state (IDLE=0, RUN=1, FINI=2), [7:4]=overflow bits in order cyc, ret, bp, bm, rest 0.
  - 0x04 CYC, 0x08 RET, 0x0C BP, 0x10 BM: counters, zero-extended to 32 bits.
  - 0x14..0x1C: read 0, writes ignored.
  - Writes to 0x04..0x10 are ignored.
- A write hits only when dbus_we_i=1 and dbus_addr_i[31:5]==BASE_ADDR[31:5]. Addresses outside the window produce no response.
- Commands (cmd field of a CTRL write):
  - 00: no-op.
  - 01 START: clear counters and overflow bits; go to RUN. Events in the command cycle are not counted.
  - 10 FINISH: go to FINI; fini_o=1 from the next cycle. Events in the command cycle ARE counted.
  - 11 CLEAR: clear counters and overflow bits; state unchanged.
- FSM:
  - IDLE -START-> RUN.
  - RUN -FINISH-> FINI.
  - IDLE -FINISH-> FINI.
  - FINI is absorbing except on reset: START and CLEAR are ignored in FINI, so counters stay frozen for readout.
- Counting happens only in RUN, once per clock edge:
  - cyc increments every cycle.
  - ret increments when retire_i=1.
  - bp increments when br_i=1.
  - bm increments when br_i=1 and br_misp_i=1.
- Wrap: the all-ones to 0 transition sets that counter's sticky overflow bit. It is cleared only by START, CLEAR or reset.
- Reads:
  - dbus_re_i with an in-window address gives dbus_rvalid_o=1 and dbus_rdata_o = register value the following cycle (1-cycle latency).
  - The value returned is the one present at the read-request edge, i.e. before that edge's increment.
  - dbus_rdata_o holds its last value when dbus_rvalid_o=0.
- Simultaneous read and write in one cycle: the read returns the pre-write value.
- Reset asserted mid-run overrides everything on that edge.

Decomposition:
- Package perf_monitor_pkg holds:
  - the state enum (IDLE, RUN, FINI);
  - the cmd localparams (CMD_NOP, CMD_START, CMD_FINISH, CMD_CLEAR);
  - the register-offset localparams (OFS_CTRL, OFS_CYC, OFS_RET, OFS_BP, OFS_BM).
- Sub-module perf_counter (CNT_W): one counter with ports clk_i, rst_n, clr_i, inc_i, en_i, cnt_o, ovf_o; instantiated four times.

Test Plan:
- Reset with AUTO_START=1, 10 idle cycles, read CYC -> rdata=10 one cycle after the request; RET=0; STATUS[1:0]=1.
- RUN: retire_i high for 7 cycles, br_i for 4 cycles of which br_misp_i=1 on 1, plus one cycle with br_misp_i=1 while br_i=0 -> RET=7, BP=4, BM=1.
- Write 0x00020000 to 0x40008000 on the same cycle as retire_i=1 -> RET includes that retire; fini_o=1 next cycle; further events and a START write leave all counters unchanged; STATUS[1:0]=2.
- CNT_W=4, run 16 cycles -> CYC wraps to 0 and STATUS[4]=1; CLEAR (0x00030000) -> CYC=0 and STATUS[4]=0.
- AUTO_START=0: cycles pass with CYC=0; START (0x00010000) with retire_i=1 that cycle -> RET=0 and counting begins the next cycle.
- Reset pulled low mid-RUN for one cycle -> all counters 0, fini_o=0, rvalid_o=0 the cycle after.
